// File: rtl/alarme_controle_if.sv
// Signal bundle between the alarm panel logic and the alarm controller:
// decoder trigger and panel requests in, siren/LED drives out.
interface alarme_controle_if;
    logic       S;
    logic       arm;
    logic       disarm;
    logic       siren;
    logic       armed;
    logic       pending;
    logic [3:0] event_count;

    modport master (
        output S, arm, disarm,
        input  siren, armed, pending, event_count
    );

    modport slave (
        input  S, arm, disarm,
        output siren, armed, pending, event_count
    );
endinterface

// File: rtl/alarme_controle.sv
// Arming controller behind the alarm decoder: exit delay, entry delay,
// bounded siren burst with automatic re-arm, and a saturating event counter.
module alarme_controle #(
    parameter int EXIT_DELAY  = 8,
    parameter int ENTRY_DELAY = 8,
    parameter int SIREN_TIME  = 16,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    alarme_controle_if.slave   bus
);
    typedef enum logic [2:0] {
        DESARMADO,
        SAIDA,
        ARMADO,
        ENTRADA,
        DISPARO
    } state_t;

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       event_count_reg, event_count_next;
    logic             siren_reg, armed_reg, pending_reg;

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        event_count_next = event_count_reg;
        case (state_reg)
            DESARMADO: begin
                if (bus.arm) begin
                    state_next = SAIDA;
                    cnt_next   = EXIT_LOAD;
                end
            end
            SAIDA: begin
                if (cnt_reg == '0) state_next = ARMADO;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            ARMADO: begin
                if (bus.S) begin
                    state_next = ENTRADA;
                    cnt_next   = ENTRY_LOAD;
                end
            end
            ENTRADA: begin
                if (cnt_reg == '0) begin
                    state_next = DISPARO;
                    cnt_next   = SIREN_LOAD;
                    if (event_count_reg != 4'hF)
                        event_count_next = event_count_reg + 4'd1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DISPARO: begin
                if (cnt_reg == '0) state_next = ARMADO;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            default: begin
                state_next = DESARMADO;
                cnt_next   = '0;
            end
        endcase
        // Disarm wins over everything, including timer expiry; the event history survives.
        if (bus.disarm) begin
            state_next       = DESARMADO;
            cnt_next         = '0;
            event_count_next = event_count_reg;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= DESARMADO;
            cnt_reg         <= '0;
            event_count_reg <= '0;
            siren_reg       <= 1'b0;
            armed_reg       <= 1'b0;
            pending_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            event_count_reg <= event_count_next;
            siren_reg       <= (state_next == DISPARO);
            armed_reg       <= (state_next == ARMADO) || (state_next == ENTRADA) ||
                               (state_next == DISPARO);
            pending_reg     <= (state_next == SAIDA) || (state_next == ENTRADA);
        end
    end

    assign bus.siren       = siren_reg;
    assign bus.armed       = armed_reg;
    assign bus.pending     = pending_reg;
    assign bus.event_count = event_count_reg;
endmodule
